// File: rtl/sha3_job_ctrl.sv
// SHA3-512 job sequencer: packs message bytes into big-endian words for the padder,
// then streams the 64-byte digest back out one byte per handshake.
module sha3_job_ctrl (
    input  logic         clk,
    input  logic         reset,
    input  logic         rx_valid,
    input  logic [7:0]   rx_data,
    input  logic         rx_last,
    output logic         rx_ready,
    output logic         core_clr,
    output logic [31:0]  pad_in,
    output logic         pad_in_ready,
    output logic         pad_is_last,
    output logic [1:0]   pad_byte_num,
    input  logic         pad_buffer_full,
    input  logic         hash_valid,
    input  logic [511:0] hash,
    output logic         tx_valid,
    output logic [7:0]   tx_data,
    input  logic         tx_ready,
    output logic         busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_ABSORB,
        S_FLUSH,
        S_WAIT_HASH,
        S_DUMP
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] word_reg, word_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic        last_seen_reg, last_seen_next;
    logic [5:0]  idx_reg, idx_next;
    logic [7:0]  tx_data_reg, tx_data_next;
    logic [5:0]  idx_inc;

    // Digest viewed as bytes, byte 0 being the most significant
    logic [7:0] hash_byte [64];
    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_hash_byte
            assign hash_byte[gi] = hash[511-8*gi -: 8];
        end
    endgenerate

    assign idx_inc = idx_reg + 6'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            word_reg      <= '0;
            cnt_reg       <= '0;
            last_seen_reg <= 1'b0;
            idx_reg       <= '0;
            tx_data_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            word_reg      <= word_next;
            cnt_reg       <= cnt_next;
            last_seen_reg <= last_seen_next;
            idx_reg       <= idx_next;
            tx_data_reg   <= tx_data_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        word_next      = word_reg;
        cnt_next       = cnt_reg;
        last_seen_next = last_seen_reg;
        idx_next       = idx_reg;
        tx_data_next   = tx_data_reg;
        rx_ready       = 1'b0;
        core_clr       = 1'b0;
        pad_in         = '0;
        pad_in_ready   = 1'b0;
        pad_is_last    = 1'b0;
        pad_byte_num   = 2'd0;
        tx_valid       = 1'b0;
        tx_data        = tx_data_reg;
        busy           = (state_reg != S_IDLE);

        case (state_reg)
            S_IDLE: begin
                if (rx_valid) state_next = S_CLR;
            end

            S_CLR: begin
                core_clr       = 1'b1;
                word_next      = '0;
                cnt_next       = '0;
                last_seen_next = 1'b0;
                state_next     = S_ABSORB;
            end

            S_ABSORB: begin
                rx_ready = (cnt_reg != 3'd4);
                if (cnt_reg == 3'd4) begin
                    pad_in_ready = 1'b1;
                    pad_in       = word_reg;
                    if (!pad_buffer_full) begin
                        cnt_next  = '0;
                        word_next = '0;
                    end
                end else if (rx_valid) begin
                    // Target byte lane is still zero, so OR-ing places the byte
                    word_next = word_reg | ({rx_data, 24'h000000} >> {cnt_reg[1:0], 3'b000});
                    cnt_next  = cnt_reg + 3'd1;
                    if (rx_last) begin
                        last_seen_next = 1'b1;
                        state_next     = S_FLUSH;
                    end
                end
            end

            S_FLUSH: begin
                pad_in_ready = 1'b1;
                pad_in       = word_reg;
                if (cnt_reg == 3'd4) begin
                    if (!pad_buffer_full) begin
                        cnt_next  = '0;
                        word_next = '0;
                    end
                end else begin
                    pad_is_last  = last_seen_reg;
                    pad_byte_num = cnt_reg[1:0];
                    if (!pad_buffer_full) begin
                        word_next  = '0;
                        state_next = S_WAIT_HASH;
                    end
                end
            end

            S_WAIT_HASH: begin
                if (hash_valid) begin
                    idx_next     = '0;
                    tx_data_next = hash_byte[0];
                    state_next   = S_DUMP;
                end
            end

            S_DUMP: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    idx_next = idx_inc;
                    if (idx_reg == 6'd63) begin
                        tx_data_next = '0;
                        state_next   = S_IDLE;
                    end else begin
                        // Preload the following byte so tx_data stays a register output
                        tx_data_next = hash_byte[idx_inc];
                    end
                end
            end

            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sha3_job_ctrl.sv
// Directed bench for sha3_job_ctrl: per-cycle vector table plus hand-written
// sequences for the digest dump and a long stalled message.
module tb_sha3_job_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         rx_valid;
    logic [7:0]   rx_data;
    logic         rx_last;
    logic         rx_ready;
    logic         core_clr;
    logic [31:0]  pad_in;
    logic         pad_in_ready;
    logic         pad_is_last;
    logic [1:0]   pad_byte_num;
    logic         pad_buffer_full;
    logic         hash_valid;
    logic [511:0] hash;
    logic         tx_valid;
    logic [7:0]   tx_data;
    logic         tx_ready;
    logic         busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sha3_job_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .rx_valid        (rx_valid),
        .rx_data         (rx_data),
        .rx_last         (rx_last),
        .rx_ready        (rx_ready),
        .core_clr        (core_clr),
        .pad_in          (pad_in),
        .pad_in_ready    (pad_in_ready),
        .pad_is_last     (pad_is_last),
        .pad_byte_num    (pad_byte_num),
        .pad_buffer_full (pad_buffer_full),
        .hash_valid      (hash_valid),
        .hash            (hash),
        .tx_valid        (tx_valid),
        .tx_data         (tx_data),
        .tx_ready        (tx_ready),
        .busy            (busy)
    );

    typedef struct {
        logic        rst;
        logic        rxv;
        logic [7:0]  d;
        logic        last;
        logic        full;
        logic        hv;
        logic        txr;
        logic [47:0] exp;
    } vec_t;

    vec_t tbl [64];
    int   nrows = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // exp = {rx_ready, core_clr, pad_in_ready, pad_is_last, pad_byte_num, pad_in, tx_valid, tx_data, busy}
    task automatic add(input logic rst, input logic rxv, input logic [7:0] d, input logic last,
                       input logic full, input logic hv, input logic txr,
                       input logic erdy, input logic eclr, input logic eprdy, input logic elast,
                       input logic [1:0] ebn, input logic [31:0] epad, input logic etxv,
                       input logic [7:0] etxd, input logic ebusy);
        tbl[nrows].rst  = rst;
        tbl[nrows].rxv  = rxv;
        tbl[nrows].d    = d;
        tbl[nrows].last = last;
        tbl[nrows].full = full;
        tbl[nrows].hv   = hv;
        tbl[nrows].txr  = txr;
        tbl[nrows].exp  = {erdy, eclr, eprdy, elast, ebn, epad, etxv, etxd, ebusy};
        nrows++;
    endtask

    // "abc" from IDLE through to the first WAIT_HASH cycle with hash_valid
    task automatic add_abc();
        add(0,1,8'h61,0,0,0,0, 0,0,0,0,2'd0,32'h0,0,8'h00,0);
        add(0,1,8'h61,0,0,0,0, 0,1,0,0,2'd0,32'h0,0,8'h00,1);
        add(0,1,8'h61,0,0,0,0, 1,0,0,0,2'd0,32'h0,0,8'h00,1);
        add(0,1,8'h62,0,0,0,0, 1,0,0,0,2'd0,32'h0,0,8'h00,1);
        add(0,1,8'h63,1,0,0,0, 1,0,0,0,2'd0,32'h0,0,8'h00,1);
        add(0,0,8'h00,0,0,0,0, 0,0,1,1,2'd3,32'h61626300,0,8'h00,1);
        add(0,0,8'h00,0,0,0,0, 0,0,0,0,2'd0,32'h0,0,8'h00,1);
        add(0,0,8'h00,0,0,1,0, 0,0,0,0,2'd0,32'h0,0,8'h00,1);
    endtask

    initial begin
        int exp_b;
        int ptr;
        int wj;
        int stall_left;
        bit stall_done;
        logic [31:0] ew;
        logic [47:0] act;

        for (int i = 0; i < 64; i++) hash[511-8*i -: 8] = 8'(i);
        reset = 1'b1; rx_valid = 0; rx_data = 0; rx_last = 0;
        pad_buffer_full = 0; hash_valid = 0; tx_ready = 0;

        // Reset state, then "abc" with a short dump
        add(1,0,8'h00,0,0,0,0, 0,0,0,0,2'd0,32'h0,0,8'h00,0);
        add(0,0,8'h00,0,0,0,0, 0,0,0,0,2'd0,32'h0,0,8'h00,0);
        add_abc();
        add(0,0,8'h00,0,0,1,0, 0,0,0,0,2'd0,32'h0,1,8'h00,1);
        add(0,0,8'h00,0,0,1,1, 0,0,0,0,2'd0,32'h0,1,8'h00,1);
        add(0,0,8'h00,0,0,1,0, 0,0,0,0,2'd0,32'h0,1,8'h01,1);
        // Reset during DUMP
        add(1,0,8'h00,0,0,1,0, 0,0,0,0,2'd0,32'h0,1,8'h01,1);
        add(0,0,8'h00,0,0,0,0, 0,0,0,0,2'd0,32'h0,0,8'h00,0);
        // 4-byte message: full word, then empty last word
        add(0,1,8'h01,0,0,0,0, 0,0,0,0,2'd0,32'h0,0,8'h00,0);
        add(0,1,8'h01,0,0,0,0, 0,1,0,0,2'd0,32'h0,0,8'h00,1);
        add(0,1,8'h01,0,0,0,0, 1,0,0,0,2'd0,32'h0,0,8'h00,1);
        add(0,1,8'h02,0,0,0,0, 1,0,0,0,2'd0,32'h0,0,8'h00,1);
        add(0,1,8'h03,0,0,0,0, 1,0,0,0,2'd0,32'h0,0,8'h00,1);
        add(0,1,8'h04,1,0,0,0, 1,0,0,0,2'd0,32'h0,0,8'h00,1);
        add(0,0,8'h00,0,0,0,0, 0,0,1,0,2'd0,32'h01020304,0,8'h00,1);
        add(0,0,8'h00,0,0,0,0, 0,0,1,1,2'd0,32'h0,0,8'h00,1);
        add(0,0,8'h00,0,0,0,0, 0,0,0,0,2'd0,32'h0,0,8'h00,1);
        add(1,0,8'h00,0,0,0,0, 0,0,0,0,2'd0,32'h0,0,8'h00,1);
        add(0,0,8'h00,0,0,0,0, 0,0,0,0,2'd0,32'h0,0,8'h00,0);
        // Reset in ABSORB with cnt=2
        add(0,1,8'h11,0,0,0,0, 0,0,0,0,2'd0,32'h0,0,8'h00,0);
        add(0,1,8'h11,0,0,0,0, 0,1,0,0,2'd0,32'h0,0,8'h00,1);
        add(0,1,8'h11,0,0,0,0, 1,0,0,0,2'd0,32'h0,0,8'h00,1);
        add(0,1,8'h22,0,0,0,0, 1,0,0,0,2'd0,32'h0,0,8'h00,1);
        add(1,1,8'h33,0,0,0,0, 1,0,0,0,2'd0,32'h0,0,8'h00,1);
        add(0,0,8'h00,0,0,0,0, 0,0,0,0,2'd0,32'h0,0,8'h00,0);
        // "abc" again, ending in DUMP at idx 0
        add_abc();
        add(0,0,8'h00,0,0,1,0, 0,0,0,0,2'd0,32'h0,1,8'h00,1);

        repeat (3) @(posedge clk);
        #1;
        for (int r = 0; r < nrows; r++) begin
            reset = tbl[r].rst; rx_valid = tbl[r].rxv; rx_data = tbl[r].d;
            rx_last = tbl[r].last; pad_buffer_full = tbl[r].full;
            hash_valid = tbl[r].hv; tx_ready = tbl[r].txr;
            @(negedge clk);
            act = {rx_ready, core_clr, pad_in_ready, pad_is_last, pad_byte_num, pad_in,
                   tx_valid, tx_data, busy};
            checks++;
            if (act !== tbl[r].exp) begin
                errors++;
                $display("FAIL row%0d: got %012h expected %012h", r, act, tbl[r].exp);
            end
            @(posedge clk);
            #1;
        end

        // Full digest dump with tx_ready toggling
        exp_b = 0;
        reset = 0;
        for (int cyc = 0; cyc < 300 && exp_b < 64; cyc++) begin
            @(negedge clk);
            hash_valid = 1;
            tx_ready = (cyc % 2 == 0);
            chk("dump_valid", 64'(tx_valid), 64'd1);
            chk("dump_byte", 64'(tx_data), 64'(exp_b));
            if (tx_valid && tx_ready) exp_b++;
        end
        chk("dump_count", 64'(exp_b), 64'd64);
        @(negedge clk);
        tx_ready = 0; hash_valid = 0;
        chk("dump_idle", {62'd0, busy, tx_valid}, 64'd0);

        // 72-byte message with a 10-cycle stall on the 5th word
        ptr = 0; wj = 0; stall_left = 0; stall_done = 0;
        for (int cyc = 0; cyc < 1000 && wj < 19; cyc++) begin
            @(negedge clk);
            rx_valid = (ptr < 72);
            rx_data  = 8'(ptr + 1);
            rx_last  = (ptr == 71);
            if (pad_in_ready && wj == 4 && !stall_done) begin
                stall_left = 10;
                stall_done = 1;
            end
            pad_buffer_full = (stall_left > 0);
            ew = (wj < 18) ? {8'(4*wj+1), 8'(4*wj+2), 8'(4*wj+3), 8'(4*wj+4)} : 32'h0;
            if (stall_left > 0) begin
                chk("stall_rx_ready", 64'(rx_ready), 64'd0);
                chk("stall_pad_ready", 64'(pad_in_ready), 64'd1);
                chk("stall_pad_in", 64'(pad_in), 64'(ew));
                stall_left--;
            end else if (pad_in_ready) begin
                chk("msg72_word", 64'(pad_in), 64'(ew));
                chk("msg72_is_last", 64'(pad_is_last), 64'(wj == 18));
                if (wj == 18) chk("msg72_byte_num", 64'(pad_byte_num), 64'd0);
                wj++;
            end
            if (rx_valid && rx_ready) ptr++;
        end
        chk("msg72_words", 64'(wj), 64'd19);
        chk("msg72_bytes", 64'(ptr), 64'd72);
        @(negedge clk);
        rx_valid = 0; rx_last = 0; pad_buffer_full = 0;
        chk("msg72_wait_hash", {61'd0, busy, pad_in_ready, rx_ready}, 64'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha3_job_ctrl.md
# sha3_job_ctrl

Job sequencer for the SHA3-512 core. It sits between the UART byte framing logic and the padder/permutation pair. It packs incoming message bytes big-endian into 32-bit words and drives the padder's word handshake, including the final partial word with its byte count. It then waits for the permutation's digest and streams all 64 digest bytes back out as a byte stream.

## Interface
No parameters: rate/digest sizes are fixed for SHA3-512.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- rx_valid  in  1  message byte available
- rx_data  in  8  message byte
- rx_last  in  1  qualifies rx_data as final byte of message
- rx_ready  out  1  byte accepted when rx_valid & rx_ready
- core_clr  out  1  one-cycle synchronous clear to padder and permutation
- pad_in  out  32  word to padder; first message byte in [31:24]
- pad_in_ready  out  1  pad_in valid
- pad_is_last  out  1  final word; only ever high with pad_in_ready
- pad_byte_num  out  2  valid bytes in final word (0..3); ignored unless pad_is_last
- pad_buffer_full  in  1  padder refuses input; word taken when pad_in_ready & ~pad_buffer_full
- hash_valid  in  1  permutation digest ready (level, stable until core_clr)
- hash  in  512  digest; first output byte hash[511:504]
- tx_valid  out  1  digest byte available
- tx_data  out  8  digest byte
- tx_ready  in  1  byte taken when tx_valid & tx_ready
- busy  out  1  state != IDLE

## Operation
- Registers: state, word[31:0], cnt[2:0] (0..4), last_seen, idx[5:0].
- IDLE: all outputs low, rx_ready=0. rx_valid=1 -> CLR. The byte is held by the sender.
- CLR: core_clr=1 for exactly one cycle. Clear word, cnt and last_seen. -> ABSORB.
- ABSORB:
  - rx_ready = (cnt<4).
  - On each accepted byte: word[31-8*cnt -: 8] <= rx_data; cnt++.
  - If the accepted byte has rx_last: last_seen<=1, -> FLUSH next cycle.
  - When cnt==4: pad_in_ready=1, pad_is_last=0. On acceptance cnt<=0 and word<=0.
  - rx_ready=0 while cnt==4, so a byte and a word transfer never coincide.
- FLUSH: rx_ready=0.
  - cnt==4: send the word with pad_is_last=0, then cnt<=0 and remain in FLUSH.
  - cnt<4: pad_in_ready=1, pad_is_last=1, pad_byte_num=cnt[1:0], unused low bytes zero. On acceptance -> WAIT_HASH.
  - A message whose length is a multiple of 4 therefore ends with an empty is_last word (byte_num=0).
- WAIT_HASH: all handshake outputs low. hash_valid=1 -> DUMP, idx<=0.
- DUMP:
  - tx_valid=1, tx_data=hash[511-8*idx -: 8].
  - On acceptance idx++. Acceptance at idx==63 -> IDLE.
  - hash is not captured; the permutation holds it until the next core_clr.
- Minimum message length is 1 byte. An empty message is not expressible.
- pad_in, pad_is_last, pad_byte_num, tx_data and tx_valid are combinational from registers only. There is no combinational path from any input to any output except rx_ready, which depends on state and cnt.

## Timing
- Reset: state=IDLE, cnt=0, last_seen=0, idx=0. All outputs 0.
- Reset mid-job:
  - Aborts immediately to IDLE.
  - No core_clr is issued by reset itself; the next job's CLR clears the core.
  - A partially sent message is discarded.
- First byte latency: rx_valid seen in IDLE. Byte accepted in the 3rd cycle (IDLE→CLR→ABSORB).
- Absorb throughput: at most 4 bytes per 5 cycles when pad_buffer_full=0.
- pad_buffer_full=1 stalls the word handshake indefinitely. Outputs hold stable and no further bytes are accepted.
- Last byte accepted in cycle t: FLUSH from t+1. If cnt<4 and not stalled, the final word is accepted in cycle t+1, and WAIT_HASH follows at t+2.
- hash_valid asserted in WAIT_HASH: first tx_valid in the next cycle.
- DUMP: one byte per cycle with tx_ready=1, so 64 cycles. tx_ready=0 holds tx_data/idx.
- busy=1 from the cycle after leaving IDLE until the cycle after the final digest byte is accepted.

## Test plan
- "abc" (0x61,0x62,0x63, last on 0x63), no stall -> exactly one padder word: pad_in=0x61626300, pad_is_last=1, pad_byte_num=3. core_clr high exactly once, before the first byte.
- 4-byte message 0x01..0x04 -> word 0x01020304 with is_last=0, then a word with is_last=1, byte_num=0, pad_in=0.
- 72-byte message with pad_buffer_full forced high for 10 cycles on the 5th word -> rx_ready=0 and pad_in held constant throughout the stall. 18 full words, then an is_last word with byte_num=0. No byte is lost or duplicated.
- hash=512'h00 01 02 … 3F pattern, tx_ready toggling 1/0 -> tx_data sequence 0x00..0x3F in order, each byte exactly once. IDLE after 0x3F.
- reset asserted in ABSORB with cnt=2 -> next cycle all outputs 0, state IDLE. A following "abc" job behaves as in test 1.
- rx_valid held high in IDLE -> rx_ready stays 0 for 2 cycles, core_clr pulses one cycle, then the byte is accepted.
